// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared types and constants for the 4-channel TDM receiver
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam int         NUM_CH    = 4;
  localparam logic [1:0] SLOT_LAST = 2'd3;

endpackage

// File: rtl/tdm_slot_ctr.sv
// rtl/tdm_slot_ctr.sv - 2-bit slot index counter with clear, load-to-1 and advance
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load_one,
  input  logic       advance,
  output logic [1:0] slot,
  output logic       last
);

  // clear wins over load, load wins over advance; advance wraps 3 -> 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= 2'd0;
    end else if (clear) begin
      slot <= 2'd0;
    end else if (load_one) begin
      slot <= 2'd1;
    end else if (advance) begin
      slot <= slot + 2'd1;
    end
  end

  assign last = (slot == SLOT_LAST);

endmodule

// File: rtl/tdm_4_demux.sv
// rtl/tdm_4_demux.sv - 4-channel TDM receive demultiplexer with frame tracking and resync
module tdm_4_demux
  import tdm_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             frame_valid,
  output logic             frame_err,
  output logic             locked,
  output logic [1:0]       slot
);

  state_t           state;
  logic [WIDTH-1:0] shadow [NUM_CH-1];
  logic             slot_last;
  logic             ctr_clear;
  logic             ctr_load;
  logic             ctr_adv;

  // Any accepted sof restarts at slot 1; mid-frame sof=0 advances; everything else parks at 0
  always_comb begin
    ctr_clear = 1'b0;
    ctr_load  = 1'b0;
    ctr_adv   = 1'b0;
    if (din_valid) begin
      if (sof) begin
        ctr_load = 1'b1;
      end else if (state == RECV && slot != 2'd0) begin
        ctr_adv = 1'b1;
      end else begin
        ctr_clear = 1'b1;
      end
    end
  end

  tdm_slot_ctr u_slot_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (ctr_clear),
    .load_one (ctr_load),
    .advance  (ctr_adv),
    .slot     (slot),
    .last     (slot_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      shadow[0]   <= '0;
      shadow[1]   <= '0;
      shadow[2]   <= '0;
      y0          <= '0;
      y1          <= '0;
      y2          <= '0;
      y3          <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (din_valid) begin
        if (sof) begin
          // an early marker abandons the partial frame but locks onto the new one
          shadow[0] <= din;
          state     <= RECV;
          if (state == RECV && slot != 2'd0) begin
            frame_err <= 1'b1;
          end
        end else if (state == RECV) begin
          if (slot == 2'd0) begin
            frame_err <= 1'b1;
            state     <= HUNT;
          end else if (slot_last) begin
            y0          <= shadow[0];
            y1          <= shadow[1];
            y2          <= shadow[2];
            y3          <= din;
            frame_valid <= 1'b1;
          end else if (slot == 2'd1) begin
            shadow[1] <= din;
          end else begin
            shadow[2] <= din;
          end
        end
      end
    end
  end

  assign locked = (state == RECV);

endmodule

// File: tb/tb_tdm_4_demux.sv
// tb/tb_tdm_4_demux.sv - scoreboard bench for tdm_4_demux
module tb_tdm_4_demux;

  logic       clk;
  logic       rst_n;
  logic [3:0] din;
  logic       din_valid;
  logic       sof;
  logic [3:0] y0, y1, y2, y3;
  logic       frame_valid;
  logic       frame_err;
  logic       locked;
  logic [1:0] slot;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          is_err;
    logic [15:0] y;
  } exp_t;

  exp_t exp_q[$];

  tdm_4_demux #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .sof         (sof),
    .y0          (y0),
    .y1          (y1),
    .y2          (y2),
    .y3          (y3),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .locked      (locked),
    .slot        (slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [15:0] y);
    exp_t e;
    e.is_err = 1'b0;
    e.y      = y;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input logic [15:0] y_held);
    exp_t e;
    e.is_err = 1'b1;
    e.y      = y_held;
    exp_q.push_back(e);
  endtask

  task automatic word(input logic s, input logic [3:0] d);
    din_valid = 1'b1;
    sof       = s;
    din       = d;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  // Monitor: every output pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && (frame_valid || frame_err)) begin
      exp_t e;
      chk("valid_err_exclusive", {31'd0, frame_valid & frame_err}, 32'd0);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse actual=fv%0d/fe%0d expected=none", frame_valid, frame_err);
      end else begin
        e = exp_q.pop_front();
        if (e.is_err != frame_err) begin
          failures++;
          $display("FAIL pulse_kind actual=err%0d expected=err%0d", frame_err, e.is_err);
        end
        chk(e.is_err ? "y_held_on_err" : "y_frame", {16'd0, y0, y1, y2, y3}, {16'd0, e.y});
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    sof       = 1'b0;
    idle(3);
    chk("reset_y", {16'd0, y0, y1, y2, y3}, 32'd0);
    chk("reset_fv", {31'd0, frame_valid}, 32'd0);
    chk("reset_fe", {31'd0, frame_err}, 32'd0);
    chk("reset_locked", {31'd0, locked}, 32'd0);
    chk("reset_slot", {30'd0, slot}, 32'd0);
    rst_n = 1'b1;
    idle(1);

    // continuous frames
    push_frame(16'h1234);
    push_frame(16'h5678);
    word(1'b1, 4'h1);
    chk("cont_locked_sof", {31'd0, locked}, 32'd1);
    chk("cont_slot_1", {30'd0, slot}, 32'd1);
    word(1'b0, 4'h2);
    word(1'b0, 4'h3);
    word(1'b0, 4'h4);
    chk("cont_fv_after_w4", {31'd0, frame_valid}, 32'd1);
    chk("cont_slot_wrap", {30'd0, slot}, 32'd0);
    word(1'b1, 4'h5);
    chk("cont_fv_one_cycle", {31'd0, frame_valid}, 32'd0);
    word(1'b0, 4'h6);
    word(1'b0, 4'h7);
    word(1'b0, 4'h8);
    chk("cont_fv_frame2", {31'd0, frame_valid}, 32'd1);
    chk("cont_locked_end", {31'd0, locked}, 32'd1);

    // gapped input
    push_frame(16'h1234);
    word(1'b1, 4'h1);
    idle(3);
    chk("gap_slot_hold1", {30'd0, slot}, 32'd1);
    word(1'b0, 4'h2);
    idle(3);
    chk("gap_slot_hold2", {30'd0, slot}, 32'd2);
    word(1'b0, 4'h3);
    idle(3);
    chk("gap_slot_hold3", {30'd0, slot}, 32'd3);
    word(1'b0, 4'h4);
    idle(3);
    chk("gap_y_held", {16'd0, y0, y1, y2, y3}, 32'h1234);

    // lock acquisition from HUNT
    do_reset();
    word(1'b0, 4'hA);
    word(1'b0, 4'hB);
    word(1'b0, 4'hC);
    chk("hunt_not_locked", {31'd0, locked}, 32'd0);
    chk("hunt_slot", {30'd0, slot}, 32'd0);
    push_frame(16'h1234);
    word(1'b1, 4'h1);
    chk("hunt_locked_rise", {31'd0, locked}, 32'd1);
    word(1'b0, 4'h2);
    word(1'b0, 4'h3);
    word(1'b0, 4'h4);

    // early sof: error while old frame still shown, then new frame
    word(1'b1, 4'h1);
    word(1'b0, 4'h2);
    push_err(16'h1234);
    push_frame(16'h9ABC);
    word(1'b1, 4'h9);
    chk("early_locked", {31'd0, locked}, 32'd1);
    chk("early_slot", {30'd0, slot}, 32'd1);
    word(1'b0, 4'hA);
    word(1'b0, 4'hB);
    word(1'b0, 4'hC);

    // missing sof
    push_frame(16'h1234);
    word(1'b1, 4'h1);
    word(1'b0, 4'h2);
    word(1'b0, 4'h3);
    word(1'b0, 4'h4);
    push_err(16'h1234);
    word(1'b0, 4'h5);
    chk("miss_locked", {31'd0, locked}, 32'd0);
    chk("miss_slot", {30'd0, slot}, 32'd0);
    word(1'b0, 4'h6);
    word(1'b0, 4'h7);
    chk("miss_still_hunt", {31'd0, locked}, 32'd0);

    // reset mid-frame
    word(1'b1, 4'h1);
    word(1'b0, 4'h2);
    rst_n = 1'b0;
    #1;
    chk("rst_async_y", {16'd0, y0, y1, y2, y3}, 32'd0);
    chk("rst_async_locked", {31'd0, locked}, 32'd0);
    chk("rst_async_slot", {30'd0, slot}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    word(1'b0, 4'h3);
    word(1'b0, 4'h4);
    idle(2);
    chk("rst_post_y", {16'd0, y0, y1, y2, y3}, 32'd0);
    chk("rst_post_locked", {31'd0, locked}, 32'd0);

    idle(2);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_4_demux.md
# tdm_4_demux

Receive end of the 4-channel time-division link whose transmit end is the 4-way selector mux: the transmitter rotates its select 0→1→2→3 and drives one channel word per slot, flagging slot 0 with a start-of-frame marker. This block tracks the slot sequence, deposits each word into its channel register, and publishes all four channels together once per complete frame. Framing violations are flagged and the block resynchronises on the next start-of-frame.

## Interface
- WIDTH, 4, bits per channel word
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- din  input  WIDTH  channel word for the current slot
- din_valid  input  1  din/sof qualify this cycle; no slot advance when low
- sof  input  1  start of frame; valid only with din_valid; marks slot 0
- y0, y1, y2, y3  output  WIDTH each  published channel words, held between frames
- frame_valid  output  1  one-cycle pulse: y0..y3 updated with a new complete frame
- frame_err  output  1  one-cycle pulse: framing violation detected
- locked  output  1  high while in RECV state
- slot  output  2  next expected slot index (0 in HUNT)

## Operation
- States: HUNT, RECV. Reset → HUNT.
- A word is accepted when din_valid=1. Cycles with din_valid=0 change nothing; frame_valid and frame_err are 0.
- HUNT: accepted word with sof=0 → discarded, no error. Accepted word with sof=1 → stored as channel 0, slot←1, → RECV.
- RECV, expected slot 1..3, sof=0: word stored in shadow register for that channel, slot increments. On slot 3: y0..y3 ← shadow0..2 + this word, frame_valid pulses, slot←0.
- RECV, expected slot 0, sof=1: stored as channel 0, slot←1 (back-to-back frames).
- RECV, expected slot 0, sof=0 (missing marker): frame_err pulses, word discarded, → HUNT, slot←0.
- RECV, expected slot 1..3, sof=1 (early marker): frame_err pulses, partial frame discarded, this word stored as channel 0, slot←1, stay RECV.
- y0..y3 change only on frame_valid; partial frames never reach outputs.
- Width rule: all channel words are exactly WIDTH bits, no extension or truncation.

## Timing
- All outputs registered. Reset values: y0..y3=0, frame_valid=0, frame_err=0, locked=0, slot=0.
- Latency: word accepted on slot 3 at edge N → y0..y3 new and frame_valid=1 during cycle after edge N.
- frame_err asserted in the cycle following the edge that accepted the offending word; never simultaneous with frame_valid.
- Minimum frame period 4 accepted words; continuous din_valid gives one frame_valid every 4 cycles.
- locked and slot reflect state after the last edge.
- rst_n assertion mid-frame: immediate clear of all state and outputs; shadow contents discarded; first frame after release requires sof.

## Structure
- Package tdm_pkg: state enum (HUNT, RECV), NUM_CH=4, SLOT_LAST=2'd3.
- Sub-module tdm_slot_ctr: 2-bit slot counter with load-to-1, clear, and advance inputs plus last-slot flag; FSM, shadow registers and output bank stay in tdm_4_demux.

## Test plan
- Reset then continuous frames: sof on word 1, din=1,2,3,4 then 5,6,7,8 → y0..y3=1,2,3,4 with frame_valid one cycle after word 4; then 5,6,7,8 four cycles later; locked=1 throughout.
- Gapped input: same frame with din_valid low for 3 cycles between each word → identical outputs, frame_valid once, slot holds during gaps.
- Lock acquisition: words A,B,C with sof=0 then sof+1,2,3,4 → no frame_err, locked rises after the sof word, y=1,2,3,4.
- Early sof: sof+1,2, then sof+9,A,B,C → frame_err pulse at the second sof, then y=9,A,B,C; y unchanged (old values) before that.
- Missing sof: complete frame 1..4, then word 5 with sof=0 → frame_err, locked=0, slot=0; following 6,7 ignored without error.
- Reset mid-frame: sof+1,2, assert rst_n low for 1 cycle, then 3,4 without sof → all outputs 0, no frame_valid, stays HUNT.
